// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline latch: owns the PC, handshakes with
// instruction memory via ihit, and handles stall/redirect/halt. Optional FETCH_PERF_EN adds counters.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  input  logic        halt,
  output logic [31:0] instruction,
  output logic [31:0] pc_plus4,
  output logic        if_valid,
`ifdef FETCH_PERF_EN
  output logic [31:0] fetch_count,
  output logic [31:0] wait_count,
`endif
  output logic        halted
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;
  logic        fetch_evt, wait_evt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      pc_q    <= {PC_INIT[31:2], 2'b00};
      instr_q <= '0;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    pcp4_d    = pcp4_q;
    valid_d   = valid_q;
    fetch_evt = 1'b0;
    wait_evt  = 1'b0;
    if (state_q == RUN) begin
      if (halt) begin
        state_d = HALTED;
        instr_d = '0;
        valid_d = 1'b0;
      end else if (redirect) begin
        // Redirect wins over stall; any ihit this cycle belongs to a squashed path.
        pc_d    = {redirect_addr[31:2], 2'b00};
        instr_d = '0;
        valid_d = 1'b0;
      end else if (stall) begin
        // Hold everything; memory simply re-reads the same PC next cycle.
      end else if (ihit) begin
        fetch_evt = 1'b1;
        pc_d      = pc_q + 32'd4;
        instr_d   = iload;
        pcp4_d    = pc_q + 32'd4;
        valid_d   = 1'b1;
      end else begin
        wait_evt = 1'b1;
        instr_d  = '0;
        valid_d  = 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    if (fetch_evt && fetch_cnt_q != 32'hFFFF_FFFF) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (wait_evt && wait_cnt_q != 32'hFFFF_FFFF) wait_cnt_d = wait_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign wait_count  = wait_cnt_q;
`endif

  assign imemaddr    = pc_q;
  assign imemREN     = nRST && (state_q == RUN);
  assign instruction = instr_q;
  assign pc_plus4    = pcp4_q;
  assign if_valid    = valid_q;
  assign halted      = (state_q == HALTED);

endmodule
